fft_peak_finder: RTL

- Downstream consumer of the FFT state machine.
- Once the FFT signals completion, this block drives the FFT's bin-select (Inspect) bus and scans a configured bin range. It reads each bin's 16-bit Result, takes its absolute value, and tracks the largest magnitude.
- It reports the winning bin index and magnitude to the tuner's pitch/display logic, with a one-cycle Done pulse and a NoPeak flag for silent input.

---
 rtl/fft_peak_finder_if.sv | 50 +++++
 rtl/fft_peak_finder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_finder_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_finder_if
//  Description : Bundle between the FFT bin memory / tuner logic and the
//                peak finder.
//                  go       - start a scan (FFT done, level or pulse)
//                  result   - signed bin value for the current inspect index
//                  inspect  - bin index driven back to the FFT
//                  busy     - high while a scan is in progress
//                  done     - one-cycle pulse at scan completion
//                  peak_bin - index of the largest-magnitude bin
//                  peak_mag - unsigned magnitude of peak_bin
//                  no_peak  - final maximum fell below the threshold
//                master : the peak finder side
//                slave  : the FFT / consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft_peak_finder_if;
  logic               go;
  logic signed [15:0] result;
  logic        [7:0]  inspect;
  logic               busy;
  logic               done;
  logic        [7:0]  peak_bin;
  logic        [15:0] peak_mag;
  logic               no_peak;

  modport master (
    input  go,
    input  result,
    output inspect,
    output busy,
    output done,
    output peak_bin,
    output peak_mag,
    output no_peak
  );

  modport slave (
    output go,
    output result,
    input  inspect,
    input  busy,
    input  done,
    input  peak_bin,
    input  peak_mag,
    input  no_peak
  );
endinterface
`default_nettype wire

// File: rtl/fft_peak_finder.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_finder
//  Description : Scans FFT bins BIN_FIRST..BIN_LAST after a start request,
//                takes |result| of each bin (saturating -32768 to 32767) and
//                reports the lowest-indexed bin holding the largest magnitude.
//  Ports       :
//    clk    - system clock, rising edge
//    rst    - synchronous active-high reset, wins over every other input
//    io_pf  - fft_peak_finder_if.master
//               go (in), result (in, signed 16), inspect (out, 8),
//               busy (out), done (out, 1-cycle pulse), peak_bin (out, 8),
//               peak_mag (out, 16), no_peak (out)
//  Parameters  :
//    BIN_FIRST - first bin scanned
//    BIN_LAST  - last bin scanned, inclusive (BIN_FIRST <= BIN_LAST <= 255)
//    RD_LAT    - cycles from an inspect change until result is valid (1..7)
//    MIN_MAG   - magnitude a peak must reach to be reported as valid
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_finder #(
  parameter int BIN_FIRST = 1,
  parameter int BIN_LAST  = 127,
  parameter int RD_LAT    = 1,
  parameter int MIN_MAG   = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fft_peak_finder_if.master io_pf
);

  localparam logic [7:0]  c_bin_first  = 8'(BIN_FIRST);
  localparam logic [7:0]  c_bin_last   = 8'(BIN_LAST);
  localparam logic [2:0]  c_lat_reload = 3'(RD_LAT - 1);
  localparam logic [15:0] c_min_mag    = 16'(MIN_MAG);
  localparam logic [15:0] c_most_neg   = 16'h8000;
  localparam logic [15:0] c_most_pos   = 16'h7FFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_max;
  logic [7:0]  r_bin;
  logic [7:0]  r_inspect;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_peak_bin;
  logic [15:0] r_peak_mag;
  logic        r_no_peak;

  // Next-state values
  state_t      w_state_nxt;
  logic [2:0]  w_cnt_nxt;
  logic [15:0] w_max_nxt;
  logic [7:0]  w_bin_nxt;
  logic [7:0]  w_inspect_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [7:0]  w_peak_bin_nxt;
  logic [15:0] w_peak_mag_nxt;
  logic        w_no_peak_nxt;

  // --------------------------------------------------------------------------
  // Magnitude of the incoming bin value. The two's-complement negation of
  // -32768 does not fit in 15 bits, so it is clamped to 32767 and the MSB of
  // the magnitude is always 0.
  // --------------------------------------------------------------------------
  logic [15:0] w_raw;
  logic [15:0] w_mag;

  always_comb begin
    w_raw = io_pf.result;
    if (!w_raw[15]) begin
      w_mag = w_raw;
    end else if (w_raw == c_most_neg) begin
      w_mag = c_most_pos;
    end else begin
      w_mag = ~w_raw + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_max_nxt      = r_max;
    w_bin_nxt      = r_bin;
    w_inspect_nxt  = r_inspect;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_peak_bin_nxt = r_peak_bin;
    w_peak_mag_nxt = r_peak_mag;
    w_no_peak_nxt  = r_no_peak;

    case (r_state)
      S_IDLE: begin
        // A level-held go re-enters here straight after FINISH and starts
        // the next scan on the following edge.
        if (io_pf.go) begin
          w_state_nxt   = S_WAIT;
          w_inspect_nxt = c_bin_first;
          w_cnt_nxt     = c_lat_reload;
          w_max_nxt     = 16'd0;
          w_bin_nxt     = c_bin_first;
          w_busy_nxt    = 1'b1;
        end
      end

      S_WAIT: begin
        // Holds inspect steady while the FFT read pipeline catches up.
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end

      S_SAMPLE: begin
        // Strict compare: on equal magnitudes the earlier (lower) bin wins.
        if (w_mag > r_max) begin
          w_max_nxt = w_mag;
          w_bin_nxt = r_inspect;
        end
        if (r_inspect == c_bin_last) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_inspect_nxt = r_inspect + 8'd1;
          w_cnt_nxt     = c_lat_reload;
          w_state_nxt   = S_WAIT;
        end
      end

      S_FINISH: begin
        // inspect is left at the last bin until the next scan or reset.
        w_peak_bin_nxt = r_bin;
        w_peak_mag_nxt = r_max;
        w_no_peak_nxt  = (r_max < c_min_mag);
        w_done_nxt     = 1'b1;
        w_busy_nxt     = 1'b0;
        w_state_nxt    = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_max      <= 16'd0;
      r_bin      <= 8'd0;
      r_inspect  <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_peak_bin <= 8'd0;
      r_peak_mag <= 16'd0;
      r_no_peak  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_max      <= w_max_nxt;
      r_bin      <= w_bin_nxt;
      r_inspect  <= w_inspect_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_peak_bin <= w_peak_bin_nxt;
      r_peak_mag <= w_peak_mag_nxt;
      r_no_peak  <= w_no_peak_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign io_pf.inspect  = r_inspect;
  assign io_pf.busy     = r_busy;
  assign io_pf.done     = r_done;
  assign io_pf.peak_bin = r_peak_bin;
  assign io_pf.peak_mag = r_peak_mag;
  assign io_pf.no_peak  = r_no_peak;

endmodule
`default_nettype wire
